// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// Each grant runs one fixed-length byte transfer, then returns the received byte.
module spi_xfer_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned XFER_CYCLES = 10,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic                        clk,
  input  logic                        Reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*SEL_W-1:0]    req_sel,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        spi_start,
  output logic [SEL_W-1:0]            spi_slave_select,
  output logic [DATA_W-1:0]           spi_tx_data,
  input  logic [DATA_W-1:0]           spi_rx_data
);

  localparam int unsigned ID_W    = $clog2(NUM_REQ);
  localparam int unsigned CNT_MAX = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic [SEL_W-1:0]  win_sel;
  logic [DATA_W-1:0] win_data;

  // Search starts at ptr (last grant + 1) and wraps around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    win_sel  = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) begin
        win_sel  = req_sel[i*SEL_W +: SEL_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Gated by Reset so every output reads 0 while reset is held.
  assign req_ready = (Reset && state == S_IDLE && found) ? (NUM_REQ'(1) << win) : '0;
  assign spi_start = (state == S_START);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state            <= S_IDLE;
      cnt              <= '0;
      ptr              <= '0;
      grant_id         <= '0;
      spi_slave_select <= '0;
      spi_tx_data      <= '0;
      rsp_data         <= '0;
      rsp_valid        <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            spi_slave_select <= win_sel;
            spi_tx_data      <= win_data;
            grant_id         <= win;
            ptr              <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
            state            <= S_START;
          end
        end
        S_START: begin
          cnt   <= CNT_W'(XFER_CYCLES - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_CAPTURE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        S_CAPTURE: begin
          rsp_data  <= spi_rx_data;
          rsp_valid <= NUM_REQ'(1) << grant_id;
          if (GAP_CYCLES == 0) begin
            state <= S_IDLE;
          end else begin
            cnt   <= CNT_W'(GAP_CYCLES - 1);
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Bench for spi_xfer_arbiter: timeline model checked every cycle plus directed
// scenarios with hand-computed expectations.
module tb_spi_xfer_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam int XF = 10;
  localparam int GP = 1;

  logic            clk = 1'b0;
  logic            Reset;
  logic [N-1:0]    req_valid;
  logic [N*SW-1:0] req_sel;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            busy;
  logic [1:0]      grant_id;
  logic            spi_start;
  logic [SW-1:0]   spi_slave_select;
  logic [DW-1:0]   spi_tx_data;
  logic [DW-1:0]   spi_rx_data;

  spi_xfer_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .SEL_W(SW), .XFER_CYCLES(XF), .GAP_CYCLES(GP)
  ) dut (
    .clk(clk), .Reset(Reset),
    .req_valid(req_valid), .req_sel(req_sel), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .grant_id(grant_id), .spi_start(spi_start),
    .spi_slave_select(spi_slave_select), .spi_tx_data(spi_tx_data),
    .spi_rx_data(spi_rx_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cnt [N];
  int rsp_cnt [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  // Model: a transfer accepted in cycle A occupies A+1 .. A+XF+2+GP, starts the
  // master in A+1, samples rx in A+XF+2 and reports in A+XF+3.
  int            m_have, m_acc, m_owner, m_ptr, m_free, m_grant, w, j;
  logic [DW-1:0] m_tx, m_rsp;
  logic [SW-1:0] m_ss;
  logic [N-1:0]  e_ready, e_rspv;
  logic          e_start, e_busy;

  initial begin
    for (int i = 0; i < N; i++) begin
      acc_cnt[i] = 0;
      rsp_cnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (!Reset) begin
      m_have = 0; m_ptr = 0; m_grant = 0; m_tx = '0; m_ss = '0; m_rsp = '0;
      chk("reset_outputs", 32'({busy, spi_start, rsp_valid, rsp_data, grant_id,
                                spi_tx_data, spi_slave_select, req_ready}), 32'd0);
    end else begin
      e_busy  = (m_have != 0) && (cyc < m_free);
      e_ready = '0;
      w       = -1;
      if (!e_busy) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (w < 0 && req_valid[j]) w = j;
        end
      end
      if (w >= 0) e_ready = N'(1) << w;
      e_start = (m_have != 0) && (cyc == m_acc + 1);
      e_rspv  = ((m_have != 0) && (cyc == m_acc + XF + 3)) ? (N'(1) << m_owner) : '0;

      chk("m_req_ready", 32'(req_ready), 32'(e_ready));
      chk("m_spi_start", 32'(spi_start), 32'(e_start));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(e_rspv));
      chk("m_rsp_data", 32'(rsp_data), 32'(m_rsp));
      chk("m_busy", 32'(busy), 32'(e_busy));
      chk("m_grant_id", 32'(grant_id), 32'(m_grant));
      chk("m_tx_data", 32'(spi_tx_data), 32'(m_tx));
      chk("m_slave_sel", 32'(spi_slave_select), 32'(m_ss));

      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) acc_cnt[i]++;
        if (rsp_valid[i]) rsp_cnt[i]++;
      end

      if ((m_have != 0) && (cyc == m_acc + XF + 2)) m_rsp = spi_rx_data;
      if (w >= 0) begin
        m_have  = 1;
        m_acc   = cyc;
        m_owner = w;
        m_grant = w;
        m_ptr   = (w + 1) % N;
        m_free  = cyc + XF + 3 + GP;
        m_tx    = req_data[w*DW +: DW];
        m_ss    = req_sel[w*SW +: SW];
      end
    end
  end

  task automatic wait_ready(input int limit, output int who, output int at);
    int n;
    n   = 0;
    who = -1;
    at  = -1;
    @(negedge clk);
    while (req_ready == '0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (req_ready != '0) begin
      for (int i = 0; i < N; i++) if (req_ready[i]) who = i;
      at = cyc;
    end else begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=none exp=grant cyc=%0d", cyc);
    end
  endtask

  task automatic wait_until(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 Reset = 1'b0;
    @(posedge clk); #1 Reset = 1'b1;
  endtask

  int who, at, prev, t0;
  int c3, r3, r0, r2;
  int rr_order [5]  = '{0, 1, 2, 3, 0};
  int fair_order [4] = '{0, 2, 0, 2};

  initial begin
    Reset = 1'b0; req_valid = '0; req_sel = '0; req_data = '0; spi_rx_data = '0;
    for (int i = 0; i < N; i++) begin
      req_sel[i*SW +: SW]  = SW'(i);
      req_data[i*DW +: DW] = DW'(8'h10 + i);
    end
    repeat (3) @(posedge clk);
    #1 Reset = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_grant", 32'(grant_id), 32'd0);

    // Contention: all four requesting continuously.
    @(posedge clk); #1 req_valid = 4'b1111; spi_rx_data = 8'hA0;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ready(40, who, at);
      chk("rr_order", 32'(who), 32'(rr_order[k]));
      if (k > 0) chk("rr_spacing", 32'(at - prev), 32'd14);
      prev = at;
      spi_rx_data = DW'(8'hA1 + k);
    end
    @(posedge clk); #1 req_valid = '0;
    wait_until(at + 16);

    // Single request from requester 1.
    @(posedge clk); #1 req_valid = 4'b0010; req_data[15:8] = 8'h5F; spi_rx_data = 8'h57;
    wait_ready(40, who, t0);
    chk("single_who", 32'(who), 32'd1);
    @(posedge clk); #1 req_valid = '0; req_data[15:8] = 8'hEE;
    wait_until(t0 + 1);
    chk("single_start", 32'(spi_start), 32'd1);
    chk("single_tx_start", 32'(spi_tx_data), 32'h5F);
    chk("single_ss_start", 32'(spi_slave_select), 32'h1);
    wait_until(t0 + 2);
    chk("single_start_one_cycle", 32'(spi_start), 32'd0);
    wait_until(t0 + 12);
    chk("single_tx_capture", 32'(spi_tx_data), 32'h5F);
    chk("single_ss_capture", 32'(spi_slave_select), 32'h1);
    chk("single_no_early_rsp", 32'(rsp_valid), 32'd0);
    wait_until(t0 + 13);
    chk("single_rsp_valid", 32'(rsp_valid), 32'b0010);
    chk("single_rsp_data", 32'(rsp_data), 32'h57);
    @(posedge clk); #1 spi_rx_data = 8'hAA;
    wait_until(t0 + 16);
    chk("rsp_data_held", 32'(rsp_data), 32'h57);
    chk("rsp_valid_pulse", 32'(rsp_valid), 32'd0);
    chk("single_idle", 32'(busy), 32'd0);

    // Fairness between requesters 0 and 2.
    pulse_reset();
    req_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_ready(40, who, at);
      chk("fair_order", 32'(who), 32'(fair_order[k]));
    end
    @(posedge clk); #1 req_valid = '0;
    wait_until(at + 16);

    // Withdrawal: requester 3 raises valid only while another transfer runs.
    c3 = acc_cnt[3]; r3 = rsp_cnt[3]; r0 = rsp_cnt[0];
    @(posedge clk); #1 req_valid = 4'b0001;
    wait_ready(40, who, t0);
    chk("withdraw_owner", 32'(who), 32'd0);
    @(posedge clk); #1 req_valid = '0;
    wait_until(t0 + 4);
    @(posedge clk); #1 req_valid = 4'b1000;
    repeat (3) @(posedge clk);
    #1 req_valid = '0;
    wait_until(t0 + 20);
    chk("withdraw_no_ready3", 32'(acc_cnt[3]), 32'(c3));
    chk("withdraw_no_rsp3", 32'(rsp_cnt[3]), 32'(r3));
    chk("withdraw_rsp0", 32'(rsp_cnt[0]), 32'(r0 + 1));

    // Reset in the middle of WAIT.
    @(posedge clk); #1 req_valid = 4'b0100;
    wait_ready(40, who, t0);
    chk("midreset_owner", 32'(who), 32'd2);
    @(posedge clk); #1 req_valid = '0;
    wait_until(t0 + 5);
    r2 = rsp_cnt[2]; r0 = rsp_cnt[0];
    @(posedge clk); #1 Reset = 1'b0;
    #1 chk("midreset_outputs_zero", 32'({busy, spi_start, rsp_valid, rsp_data, grant_id,
                                         spi_tx_data, spi_slave_select, req_ready}), 32'd0);
    @(posedge clk); #1 Reset = 1'b1; req_valid = 4'b1111;
    wait_ready(40, who, at);
    chk("midreset_prio0", 32'(who), 32'd0);
    @(posedge clk); #1 req_valid = '0;
    wait_until(at + 16);
    chk("midreset_no_rsp2", 32'(rsp_cnt[2]), 32'(r2));
    chk("midreset_rsp0", 32'(rsp_cnt[0]), 32'(r0 + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
